// File: rtl/mem_lsu_pkg.sv
// ----------------------------------------------------------------------------
// mem_lsu_pkg
// Shared encodings for the MEM-stage load/store unit:
//   - XLEN data/address width (64 only; strobe math assumes 8-byte lanes)
//   - load/store type encodings used on the EX->MEM pipeline register
//   - LSU FSM state encodings
//   - is_misaligned(): natural-alignment check on an access size and byte offset
// ----------------------------------------------------------------------------
package mem_lsu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LD  = 3'b011,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101,
        LOAD_LWU = 3'b110
    } load_type_e;

    typedef enum logic [2:0] {
        STORE_SB = 3'b000,
        STORE_SH = 3'b001,
        STORE_SW = 3'b010,
        STORE_SD = 3'b011
    } store_type_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // size: 0=byte, 1=half, 2=word, 3=double (the low two bits of both the
    // load and store type encodings carry the access size).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// ----------------------------------------------------------------------------
// mem_lsu_align
// Combinational data path of the load/store unit.
//   byte_off   in   3     byte offset within the doubleword (addr[2:0])
//   load_type  in   3     load type encoding
//   store_type in   3     store type encoding
//   store_data in   XLEN  store data, low bytes significant
//   raw_rdata  in   XLEN  raw doubleword read data from memory
//   wstrb      out  8     byte strobes (shifted by offset, truncated to 8 bits)
//   wdata      out  XLEN  store data replicated across all lanes of its size
//   load_data  out  XLEN  selected, sign/zero-extended load result
// ----------------------------------------------------------------------------
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]      byte_off,
    input  logic [2:0]      load_type,
    input  logic [2:0]      store_type,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] raw_rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted;

    // Replicating the datum into every lane means the strobe alone selects
    // which bytes land, independent of the offset.
    always_comb begin
        wstrb = 8'h00;
        wdata = store_data;
        case (store_type_e'(store_type))
            STORE_SB: begin
                wstrb = 8'h01 << byte_off;
                wdata = {8{store_data[7:0]}};
            end
            STORE_SH: begin
                wstrb = 8'h03 << byte_off;
                wdata = {4{store_data[15:0]}};
            end
            STORE_SW: begin
                wstrb = 8'h0F << byte_off;
                wdata = {2{store_data[31:0]}};
            end
            STORE_SD: begin
                wstrb = 8'hFF;
                wdata = store_data;
            end
            default: begin
                wstrb = 8'h00;
                wdata = store_data;
            end
        endcase
    end

    assign shifted = raw_rdata >> {byte_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (load_type_e'(load_type))
            LOAD_LB:  load_data = {{56{shifted[7]}},  shifted[7:0]};
            LOAD_LH:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            LOAD_LW:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            LOAD_LBU: load_data = {56'd0, shifted[7:0]};
            LOAD_LHU: load_data = {48'd0, shifted[15:0]};
            LOAD_LWU: load_data = {32'd0, shifted[31:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu
// MEM-stage load/store unit. Takes the EX->MEM register outputs, issues one
// valid/ready memory request per load/store, holds the pipeline while the
// access is outstanding and returns aligned, extended load data.
//
// Optional feature (macro MEM_MISALIGN_CHECK_EN): misaligned half/word/double
// accesses complete immediately with lsu_misalign_o=1 and no memory request.
// Without the macro lsu_misalign_o is tied 0 and such accesses are issued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lsu_mem_read_i      load present in EX->MEM register
//   lsu_mem_write_i     store present in EX->MEM register
//   lsu_load_type_i     load type encoding
//   lsu_store_type_i    store type encoding
//   lsu_addr_i          effective byte address
//   lsu_wdata_i         store data
//   lsu_stall_o         hold EX->MEM register
//   lsu_req_*           memory request channel (valid/ready)
//   lsu_resp_valid_i    response/ack for loads and stores
//   lsu_resp_rdata_i    raw doubleword read data
//   lsu_done_o          one-cycle completion pulse
//   lsu_rdata_o         extended load result, valid with lsu_done_o
//   lsu_misalign_o      misaligned-access pulse, coincident with lsu_done_o
//   lsu_state_o         FSM state (debug observation)
//
// Handshake: a request transfers on a cycle where lsu_req_valid_o and
// lsu_req_ready_i are both 1; while valid is high and ready is low every
// request field stays constant. The response is a single-cycle
// lsu_resp_valid_i pulse, accepted in the transfer cycle itself or any later
// cycle in RESP; pulses at any other time are ignored.
// ----------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_mem_read_i,
    input  logic            lsu_mem_write_i,
    input  logic [2:0]      lsu_load_type_i,
    input  logic [2:0]      lsu_store_type_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_stall_o,
    output logic            lsu_req_valid_o,
    input  logic            lsu_req_ready_i,
    output logic            lsu_req_we_o,
    output logic [XLEN-1:0] lsu_req_addr_o,
    output logic [XLEN-1:0] lsu_req_wdata_o,
    output logic [7:0]      lsu_req_wstrb_o,
    input  logic            lsu_resp_valid_i,
    input  logic [XLEN-1:0] lsu_resp_rdata_i,
    output logic            lsu_done_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_misalign_o,
    output logic [1:0]      lsu_state_o
);

    lsu_state_e      state;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [2:0]      cap_load_type;
    logic [2:0]      cap_store_type;
    logic            cap_we;
    logic [XLEN-1:0] rdata_q;
    logic [7:0]      align_wstrb;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;
    logic            mem_op;

    assign mem_op = lsu_mem_read_i | lsu_mem_write_i;

`ifdef MEM_MISALIGN_CHECK_EN
    logic       misalign_q;
    logic [1:0] in_size;
    logic       in_misaligned;

    assign in_size       = lsu_mem_write_i ? lsu_store_type_i[1:0] : lsu_load_type_i[1:0];
    assign in_misaligned = is_misaligned(in_size, lsu_addr_i[2:0]);
`endif

    // Align logic works from the captured fields so request and extraction
    // stay stable even if the pipeline register inputs wiggle.
    mem_lsu_align u_align (
        .byte_off   (cap_addr[2:0]),
        .load_type  (cap_load_type),
        .store_type (cap_store_type),
        .store_data (cap_wdata),
        .raw_rdata  (lsu_resp_rdata_i),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LSU_IDLE;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            cap_load_type  <= '0;
            cap_store_type <= '0;
            cap_we         <= 1'b0;
            rdata_q        <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (mem_op) begin
                        cap_addr       <= lsu_addr_i;
                        cap_wdata      <= lsu_wdata_i;
                        cap_load_type  <= lsu_load_type_i;
                        cap_store_type <= lsu_store_type_i;
                        cap_we         <= lsu_mem_write_i;
                        rdata_q        <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
                        if (in_misaligned) begin
                            misalign_q <= 1'b1;
                            state      <= LSU_DONE;
                        end else begin
                            state      <= LSU_REQ;
                        end
`else
                        state          <= LSU_REQ;
`endif
                    end
                end
                LSU_REQ: begin
                    if (lsu_req_ready_i) begin
                        if (lsu_resp_valid_i) begin
                            rdata_q <= cap_we ? '0 : align_load;
                            state   <= LSU_DONE;
                        end else begin
                            state   <= LSU_RESP;
                        end
                    end
                end
                LSU_RESP: begin
                    if (lsu_resp_valid_i) begin
                        rdata_q <= cap_we ? '0 : align_load;
                        state   <= LSU_DONE;
                    end
                end
                default: begin
                    // DONE: the pipeline register advances this cycle, so
                    // returning to IDLE gives exactly one bubble before the
                    // next access and never re-issues the finished one.
                    rdata_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
                    misalign_q <= 1'b0;
`endif
                    state   <= LSU_IDLE;
                end
            endcase
        end
    end

    assign lsu_stall_o     = mem_op & (state != LSU_DONE);
    assign lsu_req_valid_o = (state == LSU_REQ);
    assign lsu_req_we_o    = cap_we;
    assign lsu_req_addr_o  = {cap_addr[XLEN-1:3], 3'b000};
    assign lsu_req_wdata_o = align_wdata;
    assign lsu_req_wstrb_o = cap_we ? align_wstrb : 8'h00;
    assign lsu_done_o      = (state == LSU_DONE);
    assign lsu_rdata_o     = rdata_q;
    assign lsu_state_o     = state;
`ifdef MEM_MISALIGN_CHECK_EN
    assign lsu_misalign_o  = misalign_q;
`else
    assign lsu_misalign_o  = 1'b0;
`endif

endmodule
